// File: rtl/cache_flush_ctrl_pkg.sv
// cache_flush_ctrl_pkg: shared cache geometry helpers and flush sequencer state encoding
package cache_flush_ctrl_pkg;

   typedef enum logic [2:0] {INIT, IDLE, FLUSH, DRAIN, DONE} flush_state_t;

   function automatic int calc_lines(int cache_size, int line_size, int num_banks, int num_ways);
      return cache_size / (line_size * num_banks * num_ways);
   endfunction

   function automatic int calc_lsb(int lines);
      return (lines > 2) ? $clog2(lines) : 1;
   endfunction

endpackage

// File: rtl/cache_flush_ctrl.sv
// cache_flush_ctrl: per-bank tag init sweep and flush walker ahead of the tag store
module cache_flush_ctrl
   import cache_flush_ctrl_pkg::*;
#(
   parameter int CACHE_SIZE = 1024,
   parameter int LINE_SIZE  = 16,
   parameter int NUM_BANKS  = 1,
   parameter int NUM_WAYS   = 1,
   parameter bit WRITEBACK  = 0,
   localparam int LINES     = calc_lines(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
   localparam int LSB       = calc_lsb(LINES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_req_valid,
   output logic                flush_req_ready,
   output logic                flush_done_valid,
   input  logic                flush_done_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_init,
   output logic                out_flush_line,
   output logic [NUM_WAYS-1:0] out_flush_way_sel,
   output logic [LSB-1:0]      out_line_sel,
   input  logic                drain_busy,
   output logic                busy
);

   flush_state_t        state;
   logic [LSB-1:0]      line;
   logic [NUM_WAYS-1:0] way;
   logic                pend;
   logic                run;

   // run is low only for the cycle right after reset so no slot is shown while reset is held
   logic last_line, last_way;
   logic [NUM_WAYS-1:0] way_rot;

   // way rotation and wrap detection; the rotate degenerates to a constant when NUM_WAYS is 1
   always_comb begin
      last_line = line == LSB'(LINES - 1);
      last_way  = way[NUM_WAYS-1];
      way_rot   = (way << 1) | (way >> (NUM_WAYS - 1));
   end

   // sequencer: state, line counter, way rotator and the flush-pending flag for the re-init flush
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INIT;
         line  <= '0;
         way   <= NUM_WAYS'(1);
         pend  <= 1'b0;
         run   <= 1'b0;
      end else begin
         run <= 1'b1;
         case (state)
            INIT:
               if (run && out_ready) begin
                  line  <= last_line ? '0 : line + LSB'(1);
                  state <= last_line ? (pend ? DRAIN : IDLE) : INIT;
               end
            IDLE:
               if (flush_req_valid) begin
                  state <= WRITEBACK ? FLUSH : INIT;
                  pend  <= !WRITEBACK;
               end
            FLUSH:
               if (out_ready) begin
                  way <= way_rot;
                  if (last_way) begin
                     line  <= last_line ? '0 : line + LSB'(1);
                     state <= last_line ? DRAIN : FLUSH;
                  end
               end
            DRAIN:
               if (!drain_busy) begin
                  state <= DONE;
                  pend  <= 1'b0;
               end
            DONE:
               if (flush_done_ready) state <= IDLE;
            default: state <= INIT;
         endcase
      end
   end

   // outputs decoded straight from the registered state, so they hold while the pipeline stalls
   always_comb begin
      out_valid         = run && (state == INIT || state == FLUSH);
      out_init          = run && state == INIT;
      out_flush_line    = state == FLUSH;
      out_flush_way_sel = state == FLUSH ? way : '0;
      out_line_sel      = line;
      flush_req_ready   = state == IDLE;
      flush_done_valid  = state == DONE;
      busy              = state != IDLE;
   end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// tb_cache_flush_ctrl: directed checks of init sweep, write-back flush, stalls, drain, abort and re-init flush
module tb_cache_flush_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic out_ready, drain_busy;
   logic req, req_ready, done_valid, done_ready, out_valid, out_init, out_flush, busy;
   logic [3:0] way_sel, line_sel;
   logic req0, req_ready0, done_valid0, done_ready0, out_valid0, out_init0, out_flush0, busy0;
   logic [3:0] way_sel0, line_sel0;
   logic [10:0] slot, slot0;
   logic [2:0] status, status0;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cache_flush_ctrl #(.CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(4), .WRITEBACK(1)) dut (
      .clk(clk), .reset(reset),
      .flush_req_valid(req), .flush_req_ready(req_ready),
      .flush_done_valid(done_valid), .flush_done_ready(done_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_init(out_init), .out_flush_line(out_flush),
      .out_flush_way_sel(way_sel), .out_line_sel(line_sel),
      .drain_busy(drain_busy), .busy(busy)
   );

   cache_flush_ctrl #(.CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(4), .WRITEBACK(0)) dut0 (
      .clk(clk), .reset(reset),
      .flush_req_valid(req0), .flush_req_ready(req_ready0),
      .flush_done_valid(done_valid0), .flush_done_ready(done_ready0),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_init(out_init0), .out_flush_line(out_flush0),
      .out_flush_way_sel(way_sel0), .out_line_sel(line_sel0),
      .drain_busy(drain_busy), .busy(busy0)
   );

   assign slot    = {out_valid, out_init, out_flush, way_sel, line_sel};
   assign slot0   = {out_valid0, out_init0, out_flush0, way_sel0, line_sel0};
   assign status  = {req_ready, done_valid, busy};
   assign status0 = {req_ready0, done_valid0, busy0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] wb_slot(int l, int w);
      return {3'b101, 4'(1 << w), 4'(l)};
   endfunction

   function automatic logic [10:0] init_slot(int l);
      return {3'b110, 4'b0000, 4'(l)};
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_slot"}, 32'(slot), 32'h0);
      check({tag, "_status"}, 32'(status), 32'b001);
      check({tag, "_slot0"}, 32'(slot0), 32'h0);
      check({tag, "_status0"}, 32'(status0), 32'b001);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, cyc;
      out_ready = 1'b1; drain_busy = 1'b0;
      req = 1'b0; done_ready = 1'b0; req0 = 1'b0; done_ready0 = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("reset");
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("init_sweep", 32'(slot), 32'(init_slot(i)));
         check("init_sweep0", 32'(slot0), 32'(init_slot(i)));
      end
      @(negedge clk);
      check("idle_after_init", 32'(status), 32'b100);
      check("idle_after_init0", 32'(status0), 32'b100);
      check("idle_no_slot", 32'(out_valid), 32'h0);

      req = 1'b1; drain_busy = 1'b1;
      for (int l = 0; l < 16; l++)
         for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            req = 1'b0;
            check("wb_flush", 32'(slot), 32'(wb_slot(l, w)));
         end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("drain_hold", 32'({out_valid, status}), 32'b0001);
      end
      drain_busy = 1'b0;
      @(negedge clk);
      check("done_rise", 32'(status), 32'b011);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("done_hold", 32'(status), 32'b011);
      end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      check("idle_after_done", 32'(status), 32'b100);

      req = 1'b1; k = 0; cyc = 0;
      while (k < 64 && cyc < 1000) begin
         @(negedge clk);
         req = 1'b0;
         cyc++;
         check("stall_seq", 32'(slot), 32'(wb_slot(k / 4, k % 4)));
         out_ready = 1'($urandom_range(0, 1));
         if (out_ready) k++;
      end
      check("stall_all_accepted", 32'(k), 32'd64);
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_drain", 32'({out_valid, status}), 32'b0001);
      @(negedge clk);
      check("stall_done", 32'(status), 32'b011);
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      check("stall_idle", 32'(status), 32'b100);

      req = 1'b1;
      for (int i = 0; i <= 30; i++) begin
         @(negedge clk);
         req = 1'b0;
         check("pre_abort", 32'(slot), 32'(wb_slot(i / 4, i % 4)));
      end
      reset = 1'b1;
      @(negedge clk);
      check_reset("abort_reset");
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("abort_reinit", 32'(slot), 32'(init_slot(i)));
         check("abort_no_done", 32'(done_valid), 32'h0);
      end
      @(negedge clk);
      check("abort_idle", 32'(status), 32'b100);
      check("abort_idle0", 32'(status0), 32'b100);

      req0 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         req0 = 1'b0;
         check("wb0_flush_sweep", 32'(slot0), 32'(init_slot(i)));
      end
      @(negedge clk);
      check("wb0_drain_slot", 32'(slot0), 32'h0);
      check("wb0_drain", 32'(status0), 32'b001);
      @(negedge clk);
      check("wb0_done", 32'(status0), 32'b011);
      done_ready0 = 1'b1;
      @(negedge clk);
      done_ready0 = 1'b0;
      check("wb0_idle", 32'(status0), 32'b100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
